seq_add_sub: RTL and testbench

//  Multi-cycle N-bit adder/subtractor that time-shares one W-bit add/sub slice over N/W cycles.

---
 rtl/seq_add_sub.sv | 132 +++++++++++++
 tb/tb_seq_add_sub.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// rtl/seq_add_sub.sv - multi-cycle N-bit adder/subtractor sharing one W-bit slice
// Operands are latched on accept and processed LSB-first, one W-bit slice per cycle.
module seq_add_sub #(
   parameter int N = 256,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         cout
);
   localparam int K  = N / W;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   localparam logic [N-1:0] SLICE_MASK = N'({W{1'b1}});

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic          op_q, op_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  result_q, result_d;
   logic          cout_q, cout_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic [31:0]   sh;
   logic [W-1:0]  a_slice;
   logic [W-1:0]  b_slice;
   logic [W:0]    sum;

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_comb begin
      sh      = 32'(k_q) * 32'(W);
      a_slice = W'(a_q >> sh);
      b_slice = W'(b_q >> sh) ^ {W{op_q}};
      sum     = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, carry_q};

      state_d     = state_q;
      k_d         = k_q;
      carry_d     = carry_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      cout_d      = cout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = a;
               b_d        = b;
               op_d       = op;
               carry_d    = op;
               k_d        = '0;
               in_ready_d = 1'b0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            result_d = (result_q & ~(SLICE_MASK << sh)) | (N'(sum[W-1:0]) << sh);
            carry_d  = sum[W];
            k_d      = k_q + 1'b1;
            if (k_q == K_LAST) begin
               cout_d      = sum[W];
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         carry_q     <= 1'b0;
         op_q        <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         carry_q     <= carry_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// tb/tb_seq_add_sub.sv - self-checking bench for seq_add_sub (256/32 and 8/8)
// Full-width reference model checked every cycle, plus literal expectations.
module tb_seq_add_sub;
   localparam int N = 256;
   localparam int W = 32;
   localparam int K = N / W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, op, out_valid, out_ready, cout;
   logic [N-1:0] a, b, result;
   logic         s_in_valid, s_in_ready, s_op, s_out_valid, s_out_ready, s_cout;
   logic [7:0]   s_a, s_b, s_result;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_add_sub #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout)
   );

   seq_add_sub #(.N(8), .W(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
      .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
      .cout(s_cout)
   );

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [N:0] ref_op(input logic o, input logic [N-1:0] x, input logic [N-1:0] y);
      logic [N:0] t;
      if (!o) t = {1'b0, x} + {1'b0, y};
      else    t = {(x >= y), x - y};
      return t;
   endfunction

   // Reference model: phase 0 idle, 1 busy, 2 result presented.
   int           m_phase = 0;
   int           m_cnt   = 0;
   bit           m_live  = 1'b0;
   logic [N-1:0] m_res   = '0;
   logic         m_cout  = 1'b0;
   logic [N:0]   m_pend  = '0;

   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready", N'(in_ready), N'(m_phase == 0));
         chk("out_valid", N'(out_valid), N'(m_phase == 2));
         if (m_phase != 1) begin
            chk("result", result, m_res);
            chk("cout", N'(cout), N'(m_cout));
         end
      end
      if (!rst_n) begin
         m_live  = 1'b1;
         m_phase = 0;
         m_res   = '0;
         m_cout  = 1'b0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               m_pend  = ref_op(op, a, b);
               m_phase = 1;
               m_cnt   = 0;
            end
            1: begin
               m_cnt++;
               if (m_cnt == K) begin
                  m_phase = 2;
                  m_res   = m_pend[N-1:0];
                  m_cout  = m_pend[N];
               end
            end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   task automatic run_op(input logic o, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input int stall, input logic hold_ready,
                         output logic [N-1:0] r, output logic c, output int lat);
      int w;
      @(posedge clk); #1;
      in_valid = 1'b1; op = o; a = av; b = bv; out_ready = hold_ready;
      w = 0;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      chk("accept_wait", N'(in_ready), N'(1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0; op = ~o; a = ~av; b = ~bv;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("done_wait", N'(out_valid), N'(1'b1));
      r = result; c = cout;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("bp_result", result, r);
         chk("bp_cout", N'(cout), N'(c));
         chk("bp_in_ready", N'(in_ready), N'(1'b0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", N'(out_valid), N'(1'b0));
      chk("release_ready", N'(in_ready), N'(1'b1));
   endtask

   logic [N-1:0] r;
   logic         c;
   int           lat;
   int           w;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_op = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", N'(in_ready), N'(1'b1));
      chk("rst_out_valid", N'(out_valid), N'(1'b0));
      chk("rst_result", result, '0);
      chk("rst_cout", N'(cout), N'(1'b0));
      chk("rst_s_in_ready", N'(s_in_ready), N'(1'b1));

      run_op(1'b0, N'(1), N'(1), 0, 1'b0, r, c, lat);
      chk("t1_latency", N'(lat), N'(8));
      chk("t1_result", r, N'(2));
      chk("t1_cout", N'(c), N'(1'b0));

      run_op(1'b0, {N{1'b1}}, N'(1), 2, 1'b0, r, c, lat);
      chk("t2_result", r, '0);
      chk("t2_cout", N'(c), N'(1'b1));

      run_op(1'b1, N'(5), N'(7), 0, 1'b0, r, c, lat);
      chk("t3a_result", r, {{(N-1){1'b1}}, 1'b0});
      chk("t3a_cout", N'(c), N'(1'b0));
      run_op(1'b1, N'(7), N'(5), 0, 1'b0, r, c, lat);
      chk("t3b_result", r, N'(2));
      chk("t3b_cout", N'(c), N'(1'b1));

      run_op(1'b0, {(N/2){2'b10}}, {(N/2){2'b01}}, 0, 1'b1, r, c, lat);
      chk("alt_latency", N'(lat), N'(8));
      chk("alt_result", r, {N{1'b1}});
      chk("alt_cout", N'(c), N'(1'b0));
      run_op(1'b1, {(N/64){64'h0123_4567_89ab_cdef}}, {(N/64){64'h0123_4567_89ab_cdef}},
             1, 1'b0, r, c, lat);
      chk("eq_result", r, '0);
      chk("eq_cout", N'(c), N'(1'b1));
      run_op(1'b0, {1'b1, {(N-1){1'b0}}}, {1'b1, {(N-2){1'b0}}, 1'b1}, 0, 1'b0, r, c, lat);
      chk("msb_result", r, N'(1));
      chk("msb_cout", N'(c), N'(1'b1));

      // Back-pressure with a second request already waiting.
      @(posedge clk); #1;
      in_valid = 1'b1; op = 1'b0; a = N'(100); b = N'(23); out_ready = 1'b0;
      @(posedge clk); #1;
      a = N'(10); b = N'(20);
      w = 0;
      while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
      chk("t4_result", result, N'(123));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t4_hold_valid", N'(out_valid), N'(1'b1));
         chk("t4_hold_result", result, N'(123));
         chk("t4_hold_in_ready", N'(in_ready), N'(1'b0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("t4_ready_after_hs", N'(in_ready), N'(1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t4_pending_accepted", N'(in_ready), N'(1'b0));
      w = 0;
      while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
      chk("t4_second_result", result, N'(30));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of RUN.
      @(posedge clk); #1;
      in_valid = 1'b1; op = 1'b0; a = {N{1'b1}}; b = {N{1'b1}};
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t5_out_valid", N'(out_valid), N'(1'b0));
      chk("t5_result", result, '0);
      chk("t5_cout", N'(cout), N'(1'b0));
      chk("t5_in_ready", N'(in_ready), N'(1'b1));
      run_op(1'b0, N'(3), N'(4), 0, 1'b0, r, c, lat);
      chk("t5_after_result", r, N'(7));
      chk("t5_after_latency", N'(lat), N'(8));

      // N=8, W=8 with out_ready held high.
      @(posedge clk); #1;
      s_in_valid = 1'b1; s_op = 1'b0; s_a = 8'hFF; s_b = 8'h01;
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_a = 8'h00; s_b = 8'h00;
      chk("t6_run_valid", N'(s_out_valid), N'(1'b0));
      chk("t6_run_in_ready", N'(s_in_ready), N'(1'b0));
      @(posedge clk); #1;
      chk("t6_valid", N'(s_out_valid), N'(1'b1));
      chk("t6_result", N'(s_result), N'(8'h00));
      chk("t6_cout", N'(s_cout), N'(1'b1));
      @(posedge clk); #1;
      chk("t6_hs_valid", N'(s_out_valid), N'(1'b0));
      chk("t6_hs_in_ready", N'(s_in_ready), N'(1'b1));
      s_in_valid = 1'b1; s_op = 1'b1; s_a = 8'h10; s_b = 8'h20;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6b_valid", N'(s_out_valid), N'(1'b1));
      chk("t6b_result", N'(s_result), N'(8'hF0));
      chk("t6b_cout", N'(s_cout), N'(1'b0));
      @(posedge clk); #1;
      chk("t6b_hs_in_ready", N'(s_in_ready), N'(1'b1));

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
